// File: rtl/noc_arb_pkg.sv
// Shared types and the round-robin pick helper for the NoC injection arbiter.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package noc_arb_pkg;

    localparam int ARB_MAX_REQ = 16;
    localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    // First set bit of valid at or after ptr, wrapping modulo num.
    // Scanning from the farthest candidate back to ptr lets the nearest one win.
    // Returns ptr when nothing is valid; callers qualify with |valid.
    function automatic logic [ARB_IDX_W-1:0] rr_pick(
        input logic [ARB_MAX_REQ-1:0] valid,
        input logic [ARB_IDX_W-1:0]   ptr,
        input int                     num
    );
        logic [ARB_IDX_W-1:0] idx;
        int                   j;
        idx = ptr;
        for (int k = ARB_MAX_REQ - 1; k >= 0; k--) begin
            if (k < num) begin
                j = int'(ptr) + k;
                if (j >= num) begin
                    j = j - num;
                end
                if (valid[ARB_IDX_W'(j)]) begin
                    idx = ARB_IDX_W'(j);
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Rotate-priority encoder: picks the first valid requester at or after ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
//   valid : per-requester request bits
//   ptr   : round-robin start index
//   idx   : chosen index (meaningful only when any=1)
//   any   : at least one request present
module rr_pick_comb
    import noc_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        idx = IDX_W'(rr_pick(ARB_MAX_REQ'(valid), ARB_IDX_W'(ptr), NUM_REQ));
        any = |valid;
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin arbiter sharing one router input among NUM_REQ producers.
// Latency: request in idle cycle t -> grant/req_ready at t+1 -> noc_valid at t+2; 1 flit/cycle in a packet.
// Backpressure: noc_ready=0 holds the output register and forces req_ready to 0 until it drains.
//   clk, rst  : clock, asynchronous active-low reset
//   req_*     : per-requester flit, valid, tail flag, and accept strobe (req_ready)
//   noc_*     : registered flit to the router with valid/ready handshake and tail flag
//   grant_id  : current/last owner; busy : a packet owns the port; err_long : sticky overlong packet
module noc_inject_arbiter
    import noc_arb_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  WIDTH     = 600,
    parameter int  MAX_FLITS = 16,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   req_data [NUM_REQ],
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_last,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [WIDTH-1:0]   noc_data,
    output logic               noc_valid,
    output logic               noc_last,
    input  logic               noc_ready,
    output logic [IDX_W-1:0]   grant_id,
    output logic               busy,
    output logic               err_long
);

    localparam int               CNT_W    = $clog2(MAX_FLITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_FLITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   flit_cnt;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               accept;
    logic               own_last;
    logic               cnt_full;
    logic               release_pkt;
    logic [CNT_W-1:0]   cnt_next;
    logic [IDX_W-1:0]   next_ptr;

    rr_pick_comb #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        // The owner may push whenever the output register is empty or draining now.
        accept      = (state == ARB_LOCKED) && req_valid[grant_id] && (!noc_valid || noc_ready);
        own_last    = req_last[grant_id];
        cnt_next    = flit_cnt + 1'b1;
        cnt_full    = (cnt_next == CNT_MAX);
        release_pkt = accept && (own_last || cnt_full);
        next_ptr    = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
        req_ready           = '0;
        req_ready[grant_id] = accept;
    end

    assign busy = (state == ARB_LOCKED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            flit_cnt  <= '0;
            noc_valid <= 1'b0;
            noc_last  <= 1'b0;
            noc_data  <= '0;
            err_long  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        state    <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (accept) begin
                        if (release_pkt) begin
                            state    <= ARB_IDLE;
                            rr_ptr   <= next_ptr;
                            flit_cnt <= '0;
                            // Cut at the flit limit without a tail: flag it, leave noc_last as sent.
                            if (!own_last) begin
                                err_long <= 1'b1;
                            end
                        end else begin
                            flit_cnt <= cnt_next;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase

            // Accept wins over drain: a same-cycle accept simply replaces the register.
            if (accept) begin
                noc_data  <= req_data[grant_id];
                noc_last  <= own_last;
                noc_valid <= 1'b1;
            end else if (noc_valid && noc_ready) begin
                noc_valid <= 1'b0;
            end
        end
    end

endmodule
